// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizes for the register-file controller.
package regfile_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;
    localparam int OP_W   = 4;

    // Opcodes 10..15 are deliberately left unnamed: they are the illegal set.
    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_LDI = 4'd8,
        OP_MOV = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Instruction word layout: {op, rd, rs1, rs2}; LDI reuses {rs1, rs2} as imm8.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
    } instr_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake, register-file port and result bus of the controller.
// slave = the controller itself, master = whoever feeds it and owns the RF.
interface regfile_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;

    logic              rf_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [ADDR_W-1:0] rf_rd_addr1;
    logic [ADDR_W-1:0] rf_rd_addr2;
    logic [DATA_W-1:0] rf_rd_data1;
    logic [DATA_W-1:0] rf_rd_data2;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic              err;

    modport slave (
        input  instr_valid, instr, rf_rd_data1, rf_rd_data2,
        output instr_ready, rf_en, rf_wr_addr, rf_wr_data,
               rf_rd_addr1, rf_rd_addr2, res_valid, res_data, res_carry, err
    );

    modport master (
        output instr_valid, instr, rf_rd_data1, rf_rd_data2,
        input  instr_ready, rf_en, rf_wr_addr, rf_wr_data,
               rf_rd_addr1, rf_rd_addr2, res_valid, res_data, res_carry, err
    );

endinterface

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU: one result per opcode, carry/borrow for ADD/SUB, and an
// illegal flag for the unassigned opcodes.
module regfile_ctrl_alu
    import regfile_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [7:0]        imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              illegal_o
);

    // One extra bit catches ADD carry-out and SUB borrow (a < b wraps the MSB).
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    // Opcode decode into result, carry and illegal flag.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        result_o  = '0;
        carry_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_NOP: ;
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SHL: result_o = a_i << b_i[3:0];
            OP_SHR: result_o = a_i >> b_i[3:0];
            OP_LDI: result_o = {8'h00, imm_i};
            OP_MOV: result_o = a_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: clears the RF after reset, then runs one
// instruction at a time as IDLE -> RD (read operands) -> WB (write result).
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_ctrl_if.slave bus
);

    localparam logic [1:0] S_INIT = ST_INIT;
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RD   = ST_RD;
    localparam logic [1:0] S_WB   = ST_WB;

    localparam logic [1:0] RESET_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    instr_t            instr_q, instr_d;

    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_carry_q;
    logic              err_q;

    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_illegal;
    logic              wb_live;

    logic              rf_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [ADDR_W-1:0] rf_rd_addr1;
    logic [ADDR_W-1:0] rf_rd_addr2;
    logic              instr_ready;

    // R0 is forced to read as zero here, whatever the RF array holds.
    assign op_a = (instr_q.rs1 == '0) ? '0 : bus.rf_rd_data1;
    assign op_b = (instr_q.rs2 == '0) ? '0 : bus.rf_rd_data2;

    regfile_ctrl_alu u_alu (
        .op_i      (instr_q.op),
        .a_i       (op_a),
        .b_i       (op_b),
        .imm_i     ({instr_q.rs1, instr_q.rs2}),
        .result_o  (alu_result),
        .carry_o   (alu_carry),
        .illegal_o (alu_illegal)
    );

    // A real write-back needs a legal, non-NOP op and a destination other than R0.
    assign wb_live = (instr_q.op != OP_NOP) && !alu_illegal && (instr_q.rd != '0);

    // Next-state: INIT sweep, instruction accept, and the fixed RD/WB sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NREG - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.instr_valid && instr_ready) begin
                    instr_d = instr_t'(bus.instr);
                    state_d = S_RD;
                end
            end
            S_RD:    state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = RESET_STATE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            // NOTE: the latched instruction is reset too, so decoded outputs are
            // defined from the first cycle instead of carrying X into the RF port.
            instr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    // RF port decode from state and latched fields; qualified by rst_n so the
    // port is quiet for the whole reset period, not only after the first edge.
    always_comb begin
        rf_en       = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        rf_rd_addr1 = '0;
        rf_rd_addr2 = '0;
        instr_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_INIT: begin
                    rf_en      = 1'b1;
                    rf_wr_addr = cnt_q;
                end
                S_IDLE: instr_ready = 1'b1;
                S_RD: begin
                    rf_en       = 1'b1;
                    rf_rd_addr1 = instr_q.rs1;
                    rf_rd_addr2 = instr_q.rs2;
                end
                S_WB: begin
                    rf_en = 1'b1;
                    if (wb_live) begin
                        rf_wr_addr = instr_q.rd;
                        rf_wr_data = alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: captured on the edge leaving WB; valid/err pulse one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= (state_q == S_WB);
            err_q       <= (state_q == S_WB) && alu_illegal;
            if (state_q == S_WB) begin
                res_data_q  <= alu_result;
                res_carry_q <= alu_carry;
            end
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.rf_en       = rf_en;
    assign bus.rf_wr_addr  = rf_wr_addr;
    assign bus.rf_wr_data  = rf_wr_data;
    assign bus.rf_rd_addr1 = rf_rd_addr1;
    assign bus.rf_rd_addr2 = rf_rd_addr2;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_carry   = res_carry_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural register file attached.
module tb_regfile_ctrl;

    logic clk;
    logic rst_n;

    regfile_ctrl_if bus ();

    regfile_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_res   = 0;
    int n_wr_nz = 0;

    // Register file: no reset, registered read, write on every enabled edge.
    logic [15:0] mem [16] = '{default: 16'hDEAD};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_en) begin
            mem[bus.rf_wr_addr] <= bus.rf_wr_data;
            bus.rf_rd_data1     <= mem[bus.rf_rd_addr1];
            bus.rf_rd_data2     <= mem[bus.rf_rd_addr2];
            if (bus.rf_wr_addr != 4'd0) n_wr_nz <= n_wr_nz + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.res_valid) n_res++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    // Entered just after a reset release; walks the 16-cycle clear sweep.
    task automatic check_init();
        for (int i = 0; i < 16; i++) begin
            #1;
            check("init.en",   32'(bus.rf_en), 1);
            check("init.addr", 32'(bus.rf_wr_addr), i);
            check("init.data", 32'(bus.rf_wr_data), 0);
            check("init.rdy",  32'(bus.instr_ready), 0);
            @(negedge clk);
        end
        #1;
        check("idle.rdy", 32'(bus.instr_ready), 1);
        check("idle.en",  32'(bus.rf_en), 0);
    endtask

    // Offers ins until accepted; returns at the negedge just after the accept edge.
    task automatic start_op(input logic [15:0] ins, output bit ok);
        int n;
        n = 0;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = bus.instr_ready;
        check("accept.timeout", 32'(ok), 1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] ins, output logic [15:0] rdata, output logic rcarry,
                          output logic rerr, output logic [3:0] wa, output logic [15:0] wd);
        bit ok;
        start_op(ins, ok);
        rdata = '1; rcarry = 1'b1; rerr = 1'b1; wa = '1; wd = '1;
        if (!ok) return;
        // RD cycle
        check("rd.busy",  32'(bus.instr_ready), 0);
        check("rd.en",    32'(bus.rf_en), 1);
        check("rd.addr1", 32'(bus.rf_rd_addr1), 32'(ins[7:4]));
        check("rd.addr2", 32'(bus.rf_rd_addr2), 32'(ins[3:0]));
        check("rd.wa",    32'(bus.rf_wr_addr), 0);
        check("rd.nores", 32'(bus.res_valid), 0);
        @(negedge clk);
        // WB cycle
        check("wb.en",    32'(bus.rf_en), 1);
        check("wb.nores", 32'(bus.res_valid), 0);
        wa = bus.rf_wr_addr;
        wd = bus.rf_wr_data;
        @(negedge clk);
        // completion cycle
        check("res.valid", 32'(bus.res_valid), 1);
        check("res.rdy",   32'(bus.instr_ready), 1);
        rdata  = bus.res_data;
        rcarry = bus.res_carry;
        rerr   = bus.err;
        @(negedge clk);
        check("res.pulse", 32'(bus.res_valid), 0);
        check("err.pulse", 32'(bus.err), 0);
    endtask

    task automatic do_op(input string tag, input logic [15:0] ins, input logic [15:0] exp_data,
                         input logic exp_carry, input logic exp_err,
                         input logic [3:0] exp_wa, input logic [15:0] exp_wd);
        logic [15:0] d, wd;
        logic        c, e;
        logic [3:0]  wa;
        run_op(ins, d, c, e, wa, wd);
        check({tag, ".data"},  32'(d),  32'(exp_data));
        check({tag, ".carry"}, 32'(c),  32'(exp_carry));
        check({tag, ".err"},   32'(e),  32'(exp_err));
        check({tag, ".wa"},    32'(wa), 32'(exp_wa));
        check({tag, ".wd"},    32'(wd), 32'(exp_wd));
    endtask

    // instr_valid held high across three instructions; accepts must be 3 edges apart.
    task automatic back_to_back();
        logic [15:0] prog [3];
        int          acc [3];
        int          k, cyc, r0;
        logic        rdy;
        prog[0] = mk(4'h8, 4'h1, 4'h1, 4'h1);   // LDI R1,0x11
        prog[1] = mk(4'h8, 4'h2, 4'h2, 4'h2);   // LDI R2,0x22
        prog[2] = mk(4'h1, 4'h3, 4'h1, 4'h2);   // ADD R3,R1,R2
        acc = '{0, 0, 0};
        k   = 0;
        cyc = 0;
        r0  = n_res;
        bus.instr       = prog[0];
        bus.instr_valid = 1'b1;
        while (k < 3 && cyc < 40) begin
            rdy = bus.instr_ready;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            if (k < 3) bus.instr = prog[k];
        end
        bus.instr_valid = 1'b0;
        check("b2b.count", k, 3);
        check("b2b.gap01", acc[1] - acc[0], 3);
        check("b2b.gap12", acc[2] - acc[1], 3);
        repeat (3) @(negedge clk);
        check("b2b.results", n_res - r0, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int r0, w0;

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        repeat (2) @(negedge clk);
        check("rst.en",    32'(bus.rf_en), 0);
        check("rst.rdy",   32'(bus.instr_ready), 0);
        check("rst.valid", 32'(bus.res_valid), 0);
        check("rst.err",   32'(bus.err), 0);
        check("rst.data",  32'(bus.res_data), 0);
        check("rst.carry", 32'(bus.res_carry), 0);
        rst_n = 1'b1;
        check_init();

        do_op("ldi_r1",  mk(4'h8, 4'h1, 4'hA, 4'h5), 16'h00A5, 1'b0, 1'b0, 4'h1, 16'h00A5);
        do_op("ldi_r2",  mk(4'h8, 4'h2, 4'h0, 4'hF), 16'h000F, 1'b0, 1'b0, 4'h2, 16'h000F);
        do_op("add_r3",  mk(4'h1, 4'h3, 4'h1, 4'h2), 16'h00B4, 1'b0, 1'b0, 4'h3, 16'h00B4);
        do_op("mov_r4",  mk(4'h9, 4'h4, 4'h3, 4'h0), 16'h00B4, 1'b0, 1'b0, 4'h4, 16'h00B4);
        do_op("ldi_r1z", mk(4'h8, 4'h1, 4'h0, 4'h0), 16'h0000, 1'b0, 1'b0, 4'h1, 16'h0000);
        do_op("sub_r5",  mk(4'h2, 4'h5, 4'h1, 4'h2), 16'hFFF1, 1'b1, 1'b0, 4'h5, 16'hFFF1);
        do_op("add_r14", mk(4'h1, 4'hE, 4'h5, 4'h5), 16'hFFE2, 1'b1, 1'b0, 4'hE, 16'hFFE2);
        do_op("ldi_r1b", mk(4'h8, 4'h1, 4'hA, 4'h5), 16'h00A5, 1'b0, 1'b0, 4'h1, 16'h00A5);
        do_op("add_r0",  mk(4'h1, 4'h0, 4'h1, 4'h2), 16'h00B4, 1'b0, 1'b0, 4'h0, 16'h0000);
        do_op("mov_r6",  mk(4'h9, 4'h6, 4'h0, 4'h0), 16'h0000, 1'b0, 1'b0, 4'h6, 16'h0000);
        do_op("ldi_r9",  mk(4'h8, 4'h9, 4'h0, 4'h4), 16'h0004, 1'b0, 1'b0, 4'h9, 16'h0004);
        do_op("and_r10", mk(4'h3, 4'hA, 4'h1, 4'h2), 16'h0005, 1'b0, 1'b0, 4'hA, 16'h0005);
        do_op("or_r11",  mk(4'h4, 4'hB, 4'h1, 4'h2), 16'h00AF, 1'b0, 1'b0, 4'hB, 16'h00AF);
        do_op("xor_r12", mk(4'h5, 4'hC, 4'h1, 4'h2), 16'h00AA, 1'b0, 1'b0, 4'hC, 16'h00AA);
        do_op("shl_r13", mk(4'h6, 4'hD, 4'h1, 4'h9), 16'h0A50, 1'b0, 1'b0, 4'hD, 16'h0A50);
        do_op("shr_r8",  mk(4'h7, 4'h8, 4'h3, 4'h9), 16'h000B, 1'b0, 1'b0, 4'h8, 16'h000B);
        do_op("shl_r7",  mk(4'h6, 4'h7, 4'h1, 4'h2), 16'h8000, 1'b0, 1'b0, 4'h7, 16'h8000);
        do_op("nop",     mk(4'h0, 4'h5, 4'h1, 4'h2), 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);

        w0 = n_wr_nz;
        do_op("ill_c",   mk(4'hC, 4'h7, 4'h1, 4'h2), 16'h0000, 1'b0, 1'b1, 4'h0, 16'h0000);
        check("ill.nowrite", n_wr_nz - w0, 0);
        do_op("mov_r15", mk(4'h9, 4'hF, 4'h7, 4'h0), 16'h8000, 1'b0, 1'b0, 4'hF, 16'h8000);
        do_op("ill_f",   mk(4'hF, 4'h9, 4'h9, 4'h9), 16'h0000, 1'b0, 1'b1, 4'h0, 16'h0000);

        back_to_back();
        do_op("b2b_mov", mk(4'h9, 4'h4, 4'h3, 4'h0), 16'h0033, 1'b0, 1'b0, 4'h4, 16'h0033);
        do_op("sub_nob", mk(4'h2, 4'h5, 4'h3, 4'h1), 16'h0022, 1'b0, 1'b0, 4'h5, 16'h0022);

        // Reset pulsed during WB: operation aborts silently and the sweep restarts.
        r0 = n_res;
        start_op(mk(4'h1, 4'h3, 4'h1, 4'h2), ok);
        @(negedge clk);
        #1;
        check("abort.wb_en", 32'(bus.rf_en), 1);
        rst_n = 1'b0;
        #1;
        check("abort.en",  32'(bus.rf_en), 0);
        check("abort.rdy", 32'(bus.instr_ready), 0);
        @(negedge clk);
        check("abort.nores", 32'(bus.res_valid), 0);
        rst_n = 1'b1;
        check_init();
        check("abort.count", n_res - r0, 0);
        do_op("post_rst", mk(4'h9, 4'h4, 4'h1, 4'h0), 16'h0000, 1'b0, 1'b0, 4'h4, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero all 16 registers after reset, 0 = skip straight to IDLE.
REQ-002 SHALL have port clk  in  1  sole clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid  in  1  instruction offered.
REQ-005 SHALL have port instr_ready  out  1  controller accepts instruction this cycle.
REQ-006 SHALL have port instr  in  16  {op[15:12], rd[11:8], rs1[7:4], rs2[3:0]}.
REQ-007 SHALL have port rf_en  out  1  register-file enable; every enabled edge performs a write.
REQ-008 SHALL have port rf_wr_addr  out  4  register-file write address.
REQ-009 SHALL have port rf_wr_data  out  16  register-file write data.
REQ-010 SHALL have ports rf_rd_addr1 and rf_rd_addr2  out  4  register-file read addresses.
REQ-011 SHALL have ports rf_rd_data1 and rf_rd_data2  in  16  registered read data, valid one edge after address.
REQ-012 SHALL have port res_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port res_data  out  16  computed result.
REQ-014 SHALL have port res_carry  out  1  ADD carry-out / SUB borrow, else 0.
REQ-015 SHALL have port err  out  1  illegal opcode, pulses with res_valid.

Function
REQ-016 SHALL implement states INIT, IDLE, RD, WB; the register-file outputs SHALL be decoded from state and latched fields only.
REQ-017 INIT: rf_en=1, rf_wr_addr=cnt, rf_wr_data=0, cnt 0..15, instr_ready=0; after cnt=15 -> IDLE.
REQ-018 IDLE: rf_en=0, instr_ready=1; on instr_valid&&instr_ready latch instr -> RD.
REQ-019 RD (one cycle): rf_en=1, rf_rd_addr1=rs1, rf_rd_addr2=rs2, rf_wr_addr=0, rf_wr_data=0 -> WB.
REQ-020 R0 is the discard register and SHALL read as zero; every non-writeback enabled cycle targets R0 with data 0.
REQ-021 WB (one cycle): rf_en=1, rf_wr_addr=rd, rf_wr_data=ALU(rf_rd_data1, rf_rd_data2) -> IDLE.
REQ-022 On the edge leaving WB: res_valid=1 for one cycle, with res_data, res_carry and err registered.
REQ-023 Latency SHALL be: accept at edge A, write commits at A+2, res_valid high in cycle A+2..A+3, next accept no earlier than edge A+3.
REQ-024 Ops SHALL be: 0 NOP, 1 ADD, 2 SUB (a-b), 3 AND, 4 OR, 5 XOR, 6 SHL a<<b[3:0], 7 SHR logical a>>b[3:0], 8 LDI {8'h00,rs1,rs2}, 9 MOV a; arithmetic modulo 2^16.
REQ-025 Ops 10-15 SHALL be illegal: write to R0 with 0, res_data=0, err=1.
REQ-026 NOP, or rd=0: write SHALL go to R0 with data 0; res_data SHALL still report the computed value (NOP reports 0).
REQ-027 rs1/rs2 equal to the previous rd SHALL return the new value, since the write commits before the next RD edge.
REQ-028 instr and instr_valid SHALL be ignored outside IDLE; instr_valid held across completion is accepted at the next IDLE edge.

Reset
REQ-029 While rst_n=0: state=INIT (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0), cnt=0, all outputs 0, including rf_en, instr_ready, res_valid and err.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no res_valid; a partially written register is not guaranteed.

Structure
REQ-031 regfile_ctrl_pkg SHALL hold the opcode enumeration, the state enumeration, DATA_W=16, ADDR_W=4 and NREG=16.
REQ-032 The ALU SHALL be a combinational sub-module regfile_ctrl_alu (op, a, b, imm -> result, carry, illegal).

Verification
REQ-033 Reset release -> rf_en=1 for 16 cycles with wr_addr 0..15 and data 0, then instr_ready=1.
REQ-034 LDI R1,0xA5; LDI R2,0x0F; ADD R3,R1,R2 -> res_data 0x00B4, carry 0; MOV R4,R3 reads back 0x00B4.
REQ-035 LDI R1,0x00; SUB R5,R1,R2 (R2=0x0F) -> res_data 0xFFF1, res_carry 1.
REQ-036 ADD R0,R1,R2 -> res_data 0x00B4 reported; a following MOV R6,R0 returns 0.
REQ-037 Op 0xC -> err=1, res_data 0; no register other than R0 is written.
REQ-038 instr_valid held high for 3 back-to-back instructions -> accepts spaced exactly 3 cycles apart; rst_n pulsed during WB -> no res_valid, INIT restarts.
